// File: rtl/nco_mixer_decim_if.sv
// Configuration, RF input and decimated I/Q output bundle of the NCO mixer/decimator.
// The slave modport is the DSP block itself; the master side is the config/RF source and AM detector.
interface nco_mixer_decim_if #(
    parameter int ACC_W = 20,
    parameter int OUT_W = 16
);
    logic                    rf_in;
    logic [ACC_W-1:0]        phase_inc;
    logic [2:0]              gain;
    logic signed [OUT_W-1:0] i_out;
    logic signed [OUT_W-1:0] q_out;
    logic                    out_valid;

    modport slave (
        input  rf_in, phase_inc, gain,
        output i_out, q_out, out_valid
    );

    modport master (
        output rf_in, phase_inc, gain,
        input  i_out, q_out, out_valid
    );
endinterface

// File: rtl/nco_mixer_decim.sv
// Quadrature square-wave NCO, 1-bit RF mixer and integrate-and-dump decimator
// producing gain-scaled, saturated I/Q samples once per frame of 2^DEC_LOG2 cycles.
module nco_mixer_decim #(
    parameter int ACC_W    = 20,
    parameter int DEC_LOG2 = 6,
    parameter int OUT_W    = 16
) (
    input  logic              CLK,
    input  logic              RSTb,
    nco_mixer_decim_if.slave  bus
);
    localparam int INT_W = DEC_LOG2 + 2;
    localparam int SH_W  = DEC_LOG2 + 9;
    localparam int CMP_W = ((SH_W > OUT_W) ? SH_W : OUT_W) + 1;

    localparam logic [ACC_W-1:0]        INC_DEF = ACC_W'(20'h071F3);
    localparam logic [2:0]              GAIN_DEF = 3'd5;
    localparam logic signed [INT_W-1:0] ONE     = INT_W'(1);
    localparam logic signed [INT_W-1:0] NEG_ONE = -INT_W'(1);

    function automatic logic signed [SH_W-1:0] shift_gain(
        input logic signed [INT_W-1:0] s,
        input logic [2:0]              g
    );
        logic signed [SH_W-1:0] e;
        e = SH_W'(s);
        return e <<< g;
    endfunction

    function automatic logic signed [OUT_W-1:0] sat_out(input logic signed [SH_W-1:0] v);
        logic signed [CMP_W-1:0] w;
        logic signed [CMP_W-1:0] hi;
        logic signed [CMP_W-1:0] lo;
        w  = CMP_W'(v);
        hi = CMP_W'((1 <<< (OUT_W - 1)) - 1);
        lo = -hi - CMP_W'(1);
        if (w > hi)
            return hi[OUT_W-1:0];
        else if (w < lo)
            return lo[OUT_W-1:0];
        else
            return w[OUT_W-1:0];
    endfunction

    logic                    rf_q1, rf_q2;
    logic [ACC_W-1:0]        acc;
    logic [ACC_W-1:0]        inc_sh;
    logic [2:0]              gain_sh;
    logic [DEC_LOG2-1:0]     dec_cnt;
    logic signed [INT_W-1:0] int_i, int_q;
    logic signed [OUT_W-1:0] i_out_r, q_out_r;
    logic                    out_valid_r;

    // Mixer stage: LO quadrant and RF sign combined into +/-1 products
    logic [1:0]              qd;
    logic                    lo_i_neg, lo_q_neg, rf_neg;
    logic signed [INT_W-1:0] m_i, m_q;
    logic signed [INT_W-1:0] sum_i, sum_q;
    logic                    dump;

    assign qd       = acc[ACC_W-1 -: 2];
    assign lo_i_neg = qd[1] ^ qd[0];
    assign lo_q_neg = qd[1];
    assign rf_neg   = ~rf_q2;
    assign m_i      = (rf_neg == lo_i_neg) ? ONE : NEG_ONE;
    assign m_q      = (rf_neg == lo_q_neg) ? ONE : NEG_ONE;
    assign sum_i    = int_i + m_i;
    assign sum_q    = int_q + m_q;
    assign dump     = (dec_cnt == {DEC_LOG2{1'b1}});

    // Integrate-and-dump stage; shadow config swaps only at a frame boundary
    always_ff @(posedge CLK) begin
        if (!RSTb) begin
            rf_q1       <= 1'b0;
            rf_q2       <= 1'b0;
            acc         <= '0;
            inc_sh      <= INC_DEF;
            gain_sh     <= GAIN_DEF;
            dec_cnt     <= '0;
            int_i       <= '0;
            int_q       <= '0;
            i_out_r     <= '0;
            q_out_r     <= '0;
            out_valid_r <= 1'b0;
        end else begin
            rf_q1       <= bus.rf_in;
            rf_q2       <= rf_q1;
            acc         <= acc + inc_sh;
            dec_cnt     <= dec_cnt + DEC_LOG2'(1);
            out_valid_r <= dump;
            if (dump) begin
                int_i   <= '0;
                int_q   <= '0;
                i_out_r <= sat_out(shift_gain(sum_i, gain_sh));
                q_out_r <= sat_out(shift_gain(sum_q, gain_sh));
                inc_sh  <= bus.phase_inc;
                gain_sh <= bus.gain;
            end else begin
                int_i   <= sum_i;
                int_q   <= sum_q;
            end
        end
    end

    assign bus.i_out     = i_out_r;
    assign bus.q_out     = q_out_r;
    assign bus.out_valid = out_valid_r;
endmodule

// File: tb/tb_nco_mixer_decim.sv
// Bench for nco_mixer_decim: 16-bit and 12-bit output instances share stimulus and
// are compared every cycle against a frame-level arithmetic model plus fixed expectations.
module tb_nco_mixer_decim;
    localparam int FRAME = 64;

    logic        CLK = 1'b0;
    logic        RSTb;
    logic        rf;
    logic [19:0] pinc;
    logic [2:0]  gn;
    int          mode;

    always #5 CLK = ~CLK;

    nco_mixer_decim_if #(.ACC_W(20), .OUT_W(16)) bus16 ();
    nco_mixer_decim_if #(.ACC_W(20), .OUT_W(12)) bus12 ();

    assign bus16.rf_in     = rf;
    assign bus16.phase_inc = pinc;
    assign bus16.gain      = gn;
    assign bus12.rf_in     = rf;
    assign bus12.phase_inc = pinc;
    assign bus12.gain      = gn;

    nco_mixer_decim #(.ACC_W(20), .DEC_LOG2(6), .OUT_W(16)) dut16 (
        .CLK(CLK), .RSTb(RSTb), .bus(bus16.slave));
    nco_mixer_decim #(.ACC_W(20), .DEC_LOG2(6), .OUT_W(12)) dut12 (
        .CLK(CLK), .RSTb(RSTb), .bus(bus12.slave));

    int checks = 0;
    int errors = 0;

    // Reference model state: phase in cycles*2^20, running frame sums, shadow settings
    int ph, m_inc, m_gain, m_n, m_si, m_sq;
    bit dly[$];
    int e_i16, e_q16, e_i12, e_q12;
    bit e_v;

    function automatic int clamp(int v, int w);
        int hi;
        hi = (1 << (w - 1)) - 1;
        if (v > hi) return hi;
        if (v < -hi - 1) return -hi - 1;
        return v;
    endfunction

    task automatic model_step();
        int r, quad, lo_i, lo_q;
        if (!RSTb) begin
            ph = 0; m_inc = 'h071F3; m_gain = 5; m_n = 0; m_si = 0; m_sq = 0;
            dly = {1'b0, 1'b0};
            e_i16 = 0; e_q16 = 0; e_i12 = 0; e_q12 = 0; e_v = 1'b0;
        end else begin
            r    = dly[0] ? 1 : -1;
            quad = ph / (1 << 18);
            lo_i = (quad == 0 || quad == 3) ? 1 : -1;
            lo_q = (quad < 2) ? 1 : -1;
            m_si += r * lo_i;
            m_sq += r * lo_q;
            m_n++;
            ph = (ph + m_inc) % (1 << 20);
            dly.push_back(rf);
            void'(dly.pop_front());
            e_v = 1'b0;
            if (m_n == FRAME) begin
                e_i16 = clamp(m_si * (1 << m_gain), 16);
                e_q16 = clamp(m_sq * (1 << m_gain), 16);
                e_i12 = clamp(m_si * (1 << m_gain), 12);
                e_q12 = clamp(m_sq * (1 << m_gain), 12);
                e_v = 1'b1;
                m_inc = int'(pinc);
                m_gain = int'(gn);
                m_n = 0; m_si = 0; m_sq = 0;
            end
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(negedge CLK);
        model_step();
        checks++;
        if (bus16.i_out !== 16'(e_i16) || bus16.q_out !== 16'(e_q16) ||
            bus12.i_out !== 12'(e_i12) || bus12.q_out !== 12'(e_q12) ||
            bus16.out_valid !== e_v || bus12.out_valid !== e_v) begin
            errors++;
            $display("FAIL model t=%0t: got i16=%0d q16=%0d i12=%0d q12=%0d v=%b/%b expected %0d %0d %0d %0d v=%b",
                     $time, bus16.i_out, bus16.q_out, bus12.i_out, bus12.q_out,
                     bus16.out_valid, bus12.out_valid, e_i16, e_q16, e_i12, e_q12, e_v);
        end
        case (mode)
            0: rf = 1'b0;
            1: rf = 1'b1;
            2: rf = ~rf;
            default: rf = 1'($urandom_range(1));
        endcase
    endtask

    task automatic wait_strobe(input string name, output int n);
        n = 0;
        do begin
            cyc();
            n++;
        end while (bus16.out_valid !== 1'b1 && n < 200);
        if (bus16.out_valid !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL %s: no strobe within 200 cycles", name);
        end
    endtask

    typedef struct {
        logic [19:0] inc;
        logic [2:0]  g;
        int          rf_mode;
        int          frames;
        int          mag16;
        int          pos12;
        int          neg12;
    } row_t;

    row_t rows[8];

    initial begin
        int n, acc_d, si_d, sq_d, r, quad;

        rows[0] = '{20'h00000, 3'd5, 1, 4, 2048, 2047, -2048};
        rows[1] = '{20'h00000, 3'd7, 1, 4, 8192, 2047, -2048};
        rows[2] = '{20'h80000, 3'd5, 2, 4, 2048, 2047, -2048};
        for (int k = 3; k < 6; k++)
            rows[k] = '{20'($urandom), 3'($urandom_range(7)), 3, 3, -1, 0, 0};
        rows[6] = '{20'h00000, 3'd3, 0, 4, 512, 512, -512};
        rows[7] = '{20'h00000, 3'd5, 1, 4, 2048, 2047, -2048};

        RSTb = 1'b0; rf = 1'b0; pinc = 20'h0; gn = 3'd5; mode = 0;
        repeat (3) begin
            cyc();
            chk("rst_i16", int'(bus16.i_out), 0);
            chk("rst_q16", int'(bus16.q_out), 0);
            chk("rst_valid", int'(bus16.out_valid), 0);
        end
        RSTb = 1'b1;
        wait_strobe("first_strobe", n);
        chk("first_strobe_latency", n, 64);
        wait_strobe("second_strobe", n);
        chk("strobe_spacing", n, 64);

        for (int k = 0; k < 8; k++) begin
            pinc = rows[k].inc;
            gn   = rows[k].g;
            mode = rows[k].rf_mode;
            if (mode < 2) rf = 1'(mode);
            for (int f = 0; f < rows[k].frames; f++) begin
                wait_strobe($sformatf("row%0d_strobe", k), n);
                chk($sformatf("row%0d_spacing", k), n, 64);
                if (f >= 2 && rows[k].mag16 >= 0) begin
                    chk($sformatf("row%0d_i16", k), int'(bus16.i_out),
                        (e_i16 < 0) ? -rows[k].mag16 : rows[k].mag16);
                    chk($sformatf("row%0d_q16", k), int'(bus16.q_out),
                        (e_q16 < 0) ? -rows[k].mag16 : rows[k].mag16);
                    chk($sformatf("row%0d_i12", k), int'(bus12.i_out),
                        (e_i12 < 0) ? rows[k].neg12 : rows[k].pos12);
                    chk($sformatf("row%0d_q12", k), int'(bus12.q_out),
                        (e_q12 < 0) ? rows[k].neg12 : rows[k].pos12);
                end
            end
        end

        // Gain change mid-frame: old gain for this frame, new gain from the next
        repeat (30) cyc();
        gn = 3'd2;
        wait_strobe("gain_old_strobe", n);
        chk("gain_old_i16", int'(bus16.i_out), (e_i16 < 0) ? -2048 : 2048);
        chk("gain_old_q16", int'(bus16.q_out), (e_q16 < 0) ? -2048 : 2048);
        wait_strobe("gain_new_strobe", n);
        chk("gain_new_i16", int'(bus16.i_out), (e_i16 < 0) ? -256 : 256);
        chk("gain_new_q16", int'(bus16.q_out), (e_q16 < 0) ? -256 : 256);
        chk("gain_new_i12", int'(bus12.i_out), (e_i12 < 0) ? -256 : 256);

        // Reset mid-frame: frame discarded, defaults restored
        repeat (30) cyc();
        RSTb = 1'b0;
        cyc();
        chk("midrst_i16", int'(bus16.i_out), 0);
        chk("midrst_q16", int'(bus16.q_out), 0);
        chk("midrst_valid", int'(bus16.out_valid), 0);
        RSTb = 1'b1;
        wait_strobe("post_rst_strobe", n);
        chk("post_rst_latency", n, 64);
        acc_d = 0; si_d = 0; sq_d = 0;
        for (int k = 0; k < 64; k++) begin
            r    = (k < 2) ? -1 : 1;
            quad = acc_d >> 18;
            si_d += r * ((quad == 0 || quad == 3) ? 1 : -1);
            sq_d += r * ((quad < 2) ? 1 : -1);
            acc_d = (acc_d + 'h071F3) & 'hFFFFF;
        end
        chk("post_rst_default_i16", int'(bus16.i_out), clamp(si_d * 32, 16));
        chk("post_rst_default_q16", int'(bus16.q_out), clamp(sq_d * 32, 16));
        wait_strobe("post_rst_second", n);
        chk("post_rst_second_i16", int'(bus16.i_out), (e_i16 < 0) ? -256 : 256);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
